ram_2r1w_sync: RTL

Parametrised, synthesizable successor to the DPI-backed simulation RAM. It provides one instruction-fetch read port and one data read/write port over a single word-organised array. Both ports use registered reads and a request/valid handshake, with write-first forwarding and range checking. It sits between the core's IF/MEM stages and the memory map at `BASE_ADDR`, and replaces the combinational helper-call RAM for FPGA/ASIC builds.

---
 rtl/ram_2r1w_sync.sv | 90 +++++++++
 1 files changed

// File: rtl/ram_2r1w_sync.sv
// Word-organised 64-bit RAM with a 32-bit fetch read port and a 64-bit data read/write port.
// Both ports answer one cycle after a request, with range/alignment faults and write-first forwarding.
module ram_2r1w_sync #(
    parameter int          DEPTH     = 4096,
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
    parameter int          IDX_W     = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        imem_req,
    input  logic [63:0] imem_addr,
    output logic        imem_valid,
    output logic [31:0] imem_data,
    output logic        imem_err,
    input  logic        dmem_req,
    input  logic [63:0] dmem_addr,
    input  logic        dmem_wen,
    input  logic [63:0] dmem_wdata,
    input  logic [63:0] dmem_wmask,
    output logic        dmem_valid,
    output logic [63:0] dmem_rdata,
    output logic        dmem_err
);

    logic [63:0] mem [DEPTH];

    logic [IDX_W-1:0] i_idx;
    logic [IDX_W-1:0] d_idx;
    logic             i_in_range;
    logic             d_in_range;
    logic             i_fault;
    logic             d_we;
    logic [63:0]      d_word;
    logic [63:0]      merged;
    logic [63:0]      i_word;
    logic [31:0]      i_half;
    logic [63:0]      d_resp;

    // Any offset bit above the index field means out of range, so nothing aliases back into the array.
    assign i_idx      = IDX_W'((imem_addr - BASE_ADDR) >> 3);
    assign d_idx      = IDX_W'((dmem_addr - BASE_ADDR) >> 3);
    assign i_in_range = (imem_addr >= BASE_ADDR) &&
                        (((imem_addr - BASE_ADDR) >> (IDX_W + 3)) == 64'd0);
    assign d_in_range = (dmem_addr >= BASE_ADDR) &&
                        (((dmem_addr - BASE_ADDR) >> (IDX_W + 3)) == 64'd0);

    assign i_fault = !i_in_range || (imem_addr[1:0] != 2'b00);
    assign d_we    = dmem_req && dmem_wen && d_in_range;

    assign d_word = mem[d_idx];
    assign merged = (d_word & ~dmem_wmask) | (dmem_wdata & dmem_wmask);

    // A fetch of the word being written this cycle sees the merged value, not the stale one.
    assign i_word = (d_we && (d_idx == i_idx)) ? merged : mem[i_idx];
    assign i_half = imem_addr[2] ? i_word[63:32] : i_word[31:0];
    assign d_resp = dmem_wen ? merged : d_word;

    // The array itself is never cleared; reset only blocks writes and clears the response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_valid <= 1'b0;
            imem_err   <= 1'b0;
            imem_data  <= 32'h0;
            dmem_valid <= 1'b0;
            dmem_err   <= 1'b0;
            dmem_rdata <= 64'h0;
        end else begin
            if (d_we) begin
                mem[d_idx] <= merged;
            end

            if (imem_req) begin
                imem_valid <= 1'b1;
                imem_err   <= i_fault;
                imem_data  <= i_fault ? 32'h0 : i_half;
            end else begin
                imem_valid <= 1'b0;
            end

            if (dmem_req) begin
                dmem_valid <= 1'b1;
                dmem_err   <= !d_in_range;
                dmem_rdata <= d_in_range ? d_resp : 64'h0;
            end else begin
                dmem_valid <= 1'b0;
            end
        end
    end

endmodule
